// File: rtl/riscv_zero_hazard_ctrl.sv
// riscv_zero_hazard_ctrl: decode interlock with per-register writeback scoreboard plus flush/drain sequencing.
module riscv_zero_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_wb_en,
  input  logic       id_serial,
  input  logic       mem_busy,
  input  logic       redirect,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       kill_valid,
  input  logic [4:0] kill_rd,
  output logic       issue,
  output logic       stall_fetch,
  output logic       stall_decode,
  output logic       flush_decode,
  output logic       flush_exec,
  output logic       sb_busy,
  output logic       sb_err
);
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state, state_nx;
  logic [3:0] fcnt, fcnt_nx;
  logic [CNT_W-1:0] pend [32];
  logic [CNT_W-1:0] pend_nx [32];
  logic [CNT_W+1:0] sum, dec;
  logic [31:0] uf;
  logic hazard;
  always_comb begin
    sb_busy = 1'b0;
    for (int r = 1; r < 32; r++) sb_busy = sb_busy | (pend[r] != '0);
  end
  assign hazard = (id_uses_rs1 & (pend[id_rs1] != '0)) | (id_uses_rs2 & (pend[id_rs2] != '0))
                | (id_wb_en & (pend[id_rd] == MAX));
  assign issue = id_valid & (state == RUN) & !hazard & !mem_busy & !redirect & !(id_serial & sb_busy);
  assign stall_fetch = id_valid & !issue & (state != FLUSH) & !redirect;
  assign stall_decode = stall_fetch;
  assign flush_decode = redirect | (state == FLUSH);
  assign flush_exec = flush_decode;
  // Net per-register update; a decrement past zero clamps and flags an error.
  always_comb begin
    sum = '0;
    dec = '0;
    uf = '0;
    pend_nx[0] = '0;
    for (int r = 1; r < 32; r++) begin
      sum = {2'b00, pend[r]} + (CNT_W+2)'(issue & id_wb_en & (id_rd == 5'(r)));
      dec = (CNT_W+2)'(wb_valid & (wb_rd == 5'(r))) + (CNT_W+2)'(kill_valid & (kill_rd == 5'(r)));
      uf[r] = sum < dec;
      pend_nx[r] = uf[r] ? '0 : CNT_W'(sum - dec);
    end
  end
  always_comb begin
    state_nx = state;
    fcnt_nx = fcnt;
    if (redirect) begin
      state_nx = FLUSH;
      fcnt_nx = 4'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      state_nx = (fcnt == 4'd0) ? RUN : FLUSH;
      fcnt_nx = (fcnt == 4'd0) ? 4'd0 : fcnt - 4'd1;
    end else if (state == RUN) begin
      state_nx = (id_valid & id_serial & sb_busy) ? DRAIN : RUN;
    end else begin
      state_nx = sb_busy ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt <= '0;
      sb_err <= 1'b0;
      for (int r = 0; r < 32; r++) pend[r] <= '0;
    end else begin
      state <= state_nx;
      fcnt <= fcnt_nx;
      sb_err <= sb_err | (|uf);
      for (int r = 0; r < 32; r++) pend[r] <= pend_nx[r];
    end
  end
endmodule

// File: tb/tb_riscv_zero_hazard_ctrl.sv
// tb_riscv_zero_hazard_ctrl: per-cycle vector table for riscv_zero_hazard_ctrl plus an async-reset sequence.
module tb_riscv_zero_hazard_ctrl;
  logic clk = 1'b0, reset;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_wb_en, id_serial, mem_busy, redirect, wb_valid, kill_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd, kill_rd;
  logic issue, stall_fetch, stall_decode, flush_decode, flush_exec, sb_busy, sb_err;
  int tests = 0, fails = 0;
  typedef struct {
    string n;
    logic val, u1, u2, we, ser, mb, rdr, wv, kv;
    logic [4:0] rs1, rs2, rd, wr, kr;
    logic [4:0] e;
  } vec_t;
  vec_t tbl[$];
  riscv_zero_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_wb_en(id_wb_en),
    .id_serial(id_serial), .mem_busy(mem_busy), .redirect(redirect), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd), .issue(issue),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_decode(flush_decode),
    .flush_exec(flush_exec), .sb_busy(sb_busy), .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  // e = {issue, stall, flush, sb_busy, sb_err}
  function automatic vec_t mk(string n, int val, int rs1, int u1, int rs2, int u2, int rd, int we,
                              int ser, int mb, int rdr, int wv, int wr, int kv, int kr, logic [4:0] e);
    vec_t t;
    t.n = n; t.val = 1'(val); t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
    t.rd = 5'(rd); t.we = 1'(we); t.ser = 1'(ser); t.mb = 1'(mb); t.rdr = 1'(rdr);
    t.wv = 1'(wv); t.wr = 5'(wr); t.kv = 1'(kv); t.kr = 5'(kr); t.e = e;
    return t;
  endfunction
  task automatic drive(input vec_t t);
    id_valid = t.val; id_rs1 = t.rs1; id_uses_rs1 = t.u1; id_rs2 = t.rs2; id_uses_rs2 = t.u2;
    id_rd = t.rd; id_wb_en = t.we; id_serial = t.ser; mem_busy = t.mb; redirect = t.rdr;
    wb_valid = t.wv; wb_rd = t.wr; kill_valid = t.kv; kill_rd = t.kr;
  endtask
  task automatic check(input string n, input logic [4:0] e);
    logic [6:0] act, exp;
    act = {issue, stall_fetch, stall_decode, flush_decode, flush_exec, sb_busy, sb_err};
    exp = {e[4], e[3], e[3], e[2], e[2], e[1], e[0]};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (issue,stf,std,fld,fle,busy,err)", n, act, exp);
    end
  endtask
  initial begin
    vec_t idle;
    idle = mk("idle", 0,0,0,0,0,0,0,0,0,0,0,0,0,0, 5'b00000);
    tbl.push_back(mk("idle0",        0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00000));
    tbl.push_back(mk("x0_write",     1,0,1,0,1, 0,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("x0_untracked", 0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00000));
    tbl.push_back(mk("addi_x5",      1,1,1,0,0, 5,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("raw_x5",       1,5,1,1,1, 6,1, 0,0,0, 0,0,0,0, 5'b01010));
    tbl.push_back(mk("raw_x5_wb",    1,5,1,1,1, 6,1, 0,0,0, 1,5,0,0, 5'b01010));
    tbl.push_back(mk("raw_x5_go",    1,5,1,1,1, 6,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("wb_x6",        0,0,0,0,0, 0,0, 0,0,0, 1,6,0,0, 5'b00010));
    tbl.push_back(mk("x7_w1",        1,0,0,0,0, 7,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("x7_w2",        1,0,0,0,0, 7,1, 0,0,0, 0,0,0,0, 5'b10010));
    tbl.push_back(mk("x7_w3",        1,0,0,0,0, 7,1, 0,0,0, 0,0,0,0, 5'b10010));
    tbl.push_back(mk("x7_w4_full",   1,0,0,0,0, 7,1, 0,0,0, 0,0,0,0, 5'b01010));
    tbl.push_back(mk("x7_w4_wb",     1,0,0,0,0, 7,1, 0,0,0, 1,7,0,0, 5'b01010));
    tbl.push_back(mk("x7_w4_go",     1,0,0,0,0, 7,1, 0,0,0, 0,0,0,0, 5'b10010));
    tbl.push_back(mk("x7_wb_kill",   0,0,0,0,0, 0,0, 0,0,0, 1,7,1,7, 5'b00010));
    tbl.push_back(mk("x7_wb_last",   0,0,0,0,0, 0,0, 0,0,0, 1,7,0,0, 5'b00010));
    tbl.push_back(mk("x7_empty",     0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00000));
    tbl.push_back(mk("mem_busy",     1,0,0,0,0,10,1, 0,1,0, 0,0,0,0, 5'b01000));
    tbl.push_back(mk("mem_free",     1,0,0,0,0,10,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("wb_x10",       0,0,0,0,0, 0,0, 0,0,0, 1,10,0,0, 5'b00010));
    tbl.push_back(mk("redirect",     1,0,0,0,0, 0,0, 0,0,1, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("flush1",       1,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("flush2_mb",    1,0,0,0,0, 0,0, 0,1,0, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("run_again",    1,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("redirect_b",   0,0,0,0,0, 0,0, 0,0,1, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("flush1_b",     0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("flush2_redir", 0,0,0,0,0, 0,0, 0,0,1, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("reflush1",     0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("reflush2",     0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00100));
    tbl.push_back(mk("flush_done",   0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00000));
    tbl.push_back(mk("x8_write",     1,0,0,0,0, 8,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("fence_drain",  1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b01010));
    tbl.push_back(mk("fence_wb8",    1,0,0,0,0, 0,0, 1,0,0, 1,8,0,0, 5'b01010));
    tbl.push_back(mk("fence_empty",  1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b01000));
    tbl.push_back(mk("fence_issue",  1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("x11_write",    1,0,0,0,0,11,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("fence2_drain", 1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b01010));
    tbl.push_back(mk("drain_redir",  1,0,0,0,0, 0,0, 1,0,1, 0,0,0,0, 5'b00110));
    tbl.push_back(mk("dflush1",      1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b00110));
    tbl.push_back(mk("dflush2_wb11", 1,0,0,0,0, 0,0, 1,0,0, 1,11,0,0, 5'b00110));
    tbl.push_back(mk("fence2_issue", 1,0,0,0,0, 0,0, 1,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("x9_write",     1,0,0,0,0, 9,1, 0,0,0, 0,0,0,0, 5'b10000));
    tbl.push_back(mk("x9_wr_and_wb", 1,0,0,0,0, 9,1, 0,0,0, 1,9,0,0, 5'b10010));
    tbl.push_back(mk("x9_still_1",   0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00010));
    tbl.push_back(mk("x9_wb_kill",   0,0,0,0,0, 0,0, 0,0,0, 1,9,1,9, 5'b00010));
    tbl.push_back(mk("x9_underflow", 0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0, 5'b00001));
    drive(idle);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 check("reset_held", 5'b00000);
    @(negedge clk) reset = 1'b0;
    #2 check("reset_state", 5'b00000);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #2 check(tbl[i].n, tbl[i].e);
    end
    @(negedge clk) drive(mk("x12_write", 1,0,0,0,0,12,1, 0,0,0, 0,0,0,0, 5'b0));
    #2 check("x12_write", 5'b10001);
    @(negedge clk) drive(mk("redir", 0,0,0,0,0,0,0, 0,0,1, 0,0,0,0, 5'b0));
    #2 check("pre_reset_redirect", 5'b00111);
    @(negedge clk) drive(idle);
    #2 check("pre_reset_flush", 5'b00111);
    #1 reset = 1'b1;
    #1 check("async_reset", 5'b00000);
    @(negedge clk) reset = 1'b0;
    #2 check("post_reset", 5'b00000);
    @(negedge clk) drive(mk("read_x12", 1,12,1,0,0,0,0, 0,0,0, 0,0,0,0, 5'b0));
    #2 check("x12_cleared", 5'b10000);
    @(negedge clk) drive(mk("x13_write", 1,0,0,0,0,13,1, 0,0,0, 0,0,0,0, 5'b0));
    #2 check("x13_write", 5'b10000);
    @(negedge clk) drive(mk("read_x0", 1,0,1,0,1,0,1, 0,0,0, 0,0,0,0, 5'b0));
    #2 check("x0_never_stalls", 5'b10010);
    @(negedge clk) drive(idle);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
